// File: rtl/riscv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the RISC-V datapath memory path:
//               MemRW operation encodings, the memory-port arbiter state
//               enum and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Default bus widths
    localparam int c_default_aw = 32;
    localparam int c_default_dw = 32;

    // Width of the data-grant streak counter (DATA_STREAK is at most 15)
    localparam int c_streak_w = 4;
    // Width of the transaction wait counter (TIMEOUT is at most 255)
    localparam int c_wdog_w = 8;

    // MemRW encodings from the Controller; 2'b11 is reserved (no request)
    localparam logic [1:0] MEMRW_NONE  = 2'b00;
    localparam logic [1:0] MEMRW_LOAD  = 2'b01;
    localparam logic [1:0] MEMRW_STORE = 2'b10;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_watchdog
// Description : Counts the cycles a memory transaction has been outstanding
//               and flags the cycle in which it has been outstanding for
//               'limit' cycles. A limit of 0 disables the watchdog.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset
//               start   - transaction granted; counting begins next cycle
//               ack     - memory acknowledged; stops counting
//               limit   - terminal count
//               expired - combinational: current cycle is the limit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_watchdog #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ack,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic          r_run;
    logic [CW-1:0] r_cnt;

    // r_cnt holds (cycles outstanding - 1), so the Nth cycle of the
    // transaction is the one where r_cnt == N-1.
    assign expired = r_run && (limit != '0) && (r_cnt == (limit - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            if (ack || expired) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, variable-latency memory between the
//               instruction-fetch and load/store paths. One transaction at a
//               time; completion is reported with a one-cycle valid pulse.
// Ports       : if_req/if_addr          - fetch request
//               if_rdata/if_valid       - fetch completion
//               d_req/d_MemRW/d_addr/d_wdata - data request
//               d_rdata/d_valid         - data completion (rdata 0 for stores)
//               err                     - completion was a timeout abort
//               stall                   - a requester is still waiting
//               mem_req/mem_we/mem_addr/mem_wdata - memory request
//               mem_rdata/mem_ack       - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int AW          = c_default_aw,
    parameter int DW          = c_default_dw,
    parameter int DATA_STREAK = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic [1:0]    d_MemRW,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          err,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(DATA_STREAK);
    localparam logic [c_wdog_w-1:0]   c_timeout    = c_wdog_w'(TIMEOUT);

    arb_state_e            r_state,     w_state_nx;
    logic                  r_mem_req,   w_mem_req_nx;
    logic                  r_mem_we,    w_mem_we_nx;
    logic [AW-1:0]         r_mem_addr,  w_mem_addr_nx;
    logic [DW-1:0]         r_mem_wdata, w_mem_wdata_nx;
    logic [DW-1:0]         r_if_rdata,  w_if_rdata_nx;
    logic [DW-1:0]         r_d_rdata,   w_d_rdata_nx;
    logic                  r_if_valid,  w_if_valid_nx;
    logic                  r_d_valid,   w_d_valid_nx;
    logic                  r_err,       w_err_nx;
    logic [c_streak_w-1:0] r_streak,    w_streak_nx;

    logic          w_d_req_eff;
    logic          w_if_cand;
    logic          w_d_cand;
    logic          w_grant_d;
    logic          w_grant_if;
    logic          w_busy;
    logic          w_start;
    logic          w_expired;
    logic [DW-1:0] w_rdata_cap;

    assign w_d_req_eff = d_req && ((d_MemRW == MEMRW_LOAD) || (d_MemRW == MEMRW_STORE));

    // A requester whose response is being presented this cycle is still
    // holding its request; masking with valid stops it being re-granted.
    assign w_if_cand = if_req & ~r_if_valid;
    assign w_d_cand  = w_d_req_eff & ~r_d_valid;

    // Data has priority unless it has already won DATA_STREAK times in a
    // row against a waiting fetch.
    assign w_grant_d  = w_d_cand & ~(w_if_cand & (r_streak == c_streak_max));
    assign w_grant_if = w_if_cand & ~w_grant_d;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_rdata_cap = (mem_ack && !r_mem_we) ? mem_rdata : '0;

    mem_watchdog #(
        .CW (c_wdog_w)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .ack     (mem_ack & w_busy),
        .limit   (c_timeout),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_err       <= 1'b0;
            r_streak    <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_mem_req   <= w_mem_req_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_if_rdata  <= w_if_rdata_nx;
            r_d_rdata   <= w_d_rdata_nx;
            r_if_valid  <= w_if_valid_nx;
            r_d_valid   <= w_d_valid_nx;
            r_err       <= w_err_nx;
            r_streak    <= w_streak_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_mem_req_nx   = r_mem_req;
        w_mem_we_nx    = r_mem_we;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_if_rdata_nx  = r_if_rdata;
        w_d_rdata_nx   = r_d_rdata;
        w_if_valid_nx  = 1'b0;
        w_d_valid_nx   = 1'b0;
        w_err_nx       = 1'b0;
        w_streak_nx    = r_streak;
        w_start        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nx     = ST_BUSY_D;
                    w_mem_req_nx   = 1'b1;
                    w_mem_we_nx    = (d_MemRW == MEMRW_STORE);
                    w_mem_addr_nx  = d_addr;
                    w_mem_wdata_nx = d_wdata;
                    w_start        = 1'b1;
                    if (w_if_cand) begin
                        if (r_streak != c_streak_max) begin
                            w_streak_nx = r_streak + 1'b1;
                        end
                    end else begin
                        w_streak_nx = '0;
                    end
                end else if (w_grant_if) begin
                    w_state_nx     = ST_BUSY_IF;
                    w_mem_req_nx   = 1'b1;
                    w_mem_we_nx    = 1'b0;
                    w_mem_addr_nx  = if_addr;
                    w_mem_wdata_nx = '0;
                    w_start        = 1'b1;
                    w_streak_nx    = '0;
                end
            end

            ST_BUSY_IF, ST_BUSY_D: begin
                // An ack in the limit cycle wins over the timeout.
                if (mem_ack || w_expired) begin
                    w_state_nx   = ST_IDLE;
                    w_mem_req_nx = 1'b0;
                    w_mem_we_nx  = 1'b0;
                    w_err_nx     = ~mem_ack;
                    if (r_state == ST_BUSY_IF) begin
                        w_if_valid_nx = 1'b1;
                        w_if_rdata_nx = w_rdata_cap;
                    end else begin
                        w_d_valid_nx = 1'b1;
                        w_d_rdata_nx = w_rdata_cap;
                    end
                end
            end

            default: begin
                w_state_nx   = ST_IDLE;
                w_mem_req_nx = 1'b0;
            end
        endcase
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign err       = r_err;
    assign stall     = (if_req & ~r_if_valid) | (w_d_req_eff & ~r_d_valid);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios
//               pin latencies, priorities, timeout and reset with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    localparam int c_aw = 32;
    localparam int c_dw = 32;
    localparam int c_ds = 4;
    localparam int c_to = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            if_req = 1'b0;
    logic [c_aw-1:0] if_addr = '0;
    logic [c_dw-1:0] if_rdata;
    logic            if_valid;
    logic            d_req = 1'b0;
    logic [1:0]      d_MemRW = MEMRW_NONE;
    logic [c_aw-1:0] d_addr = '0;
    logic [c_dw-1:0] d_wdata = '0;
    logic [c_dw-1:0] d_rdata;
    logic            d_valid;
    logic            err;
    logic            stall;
    logic            mem_req;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic [c_dw-1:0] mem_rdata = '0;
    logic            mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW          (c_aw),
        .DW          (c_dw),
        .DATA_STREAK (c_ds),
        .TIMEOUT     (c_to)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_MemRW   (d_MemRW),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .err       (err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit deff(input logic r, input logic [1:0] rw);
        return r && (rw == MEMRW_LOAD || rw == MEMRW_STORE);
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference model: who owns the memory, what was
    // issued, how long it has been outstanding, and what completes next.
    // ------------------------------------------------------------------
    int              m_owner  = 0;   // 0 none, 1 fetch, 2 data
    logic [c_aw-1:0] m_addr   = '0;
    logic [c_dw-1:0] m_wdata  = '0;
    logic            m_we     = 1'b0;
    int              m_hi     = 0;   // cycles mem_req has been high so far
    logic            m_ifv    = 1'b0;
    logic            m_dv     = 1'b0;
    logic            m_err    = 1'b0;
    logic [c_dw-1:0] m_rdata  = '0;
    int              m_streak = 0;
    bit              m_ic, m_dc;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_owner = 0; m_hi = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_ifv = 1'b0; m_dv = 1'b0; m_err = 1'b0; m_rdata = '0; m_streak = 0;
        end else begin
            m_ic  = if_req && !m_ifv;
            m_dc  = deff(d_req, d_MemRW) && !m_dv;
            m_ifv = 1'b0; m_dv = 1'b0; m_err = 1'b0;
            if (m_owner == 0) begin
                if (m_dc && !(m_ic && m_streak == c_ds)) begin
                    m_owner = 2; m_addr = d_addr; m_wdata = d_wdata;
                    m_we = (d_MemRW == MEMRW_STORE); m_hi = 0;
                    m_streak = m_ic ? ((m_streak < c_ds) ? m_streak + 1 : c_ds) : 0;
                end else if (m_ic) begin
                    m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_hi = 0; m_streak = 0;
                end
            end else begin
                m_hi++;
                if (mem_ack || (c_to != 0 && m_hi == c_to)) begin
                    m_err   = !mem_ack;
                    m_rdata = (mem_ack && !m_we) ? mem_rdata : '0;
                    if (m_owner == 1) m_ifv = 1'b1; else m_dv = 1'b1;
                    m_owner = 0;
                end
            end
        end
    end

    // Single compare process: registered outputs against the model, and
    // stall against the current inputs, every cycle.
    initial forever begin
        @(negedge clk);
        #2;
        chk("mem_req", mem_req, m_owner != 0);
        if (m_owner != 0) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_valid", if_valid, m_ifv);
        chk("d_valid", d_valid, m_dv);
        if (m_ifv || m_dv) chk("err", err, m_err);
        if (m_ifv) chk("if_rdata", if_rdata, m_rdata);
        if (m_dv)  chk("d_rdata", d_rdata, m_rdata);
        chk("stall", stall, (if_req && !m_ifv) || (deff(d_req, d_MemRW) && !m_dv));
    end

    // ------------------------------------------------------------------
    // Memory responder and stimulus helpers
    // ------------------------------------------------------------------
    int              lat         = 1;
    bit              ack_rand    = 0;
    int              ack_div     = 2;
    bit              idle_ack_en = 0;
    bit              rd_fix      = 0;
    logic [c_dw-1:0] rd_val      = '0;

    task automatic step();
        @(negedge clk);
        #1;
        if (m_owner != 0) mem_ack = ack_rand ? ($urandom_range(0, ack_div) == 0) : (m_hi == lat);
        else              mem_ack = idle_ack_en && ($urandom_range(0, 3) == 0);
        mem_rdata = rd_fix ? rd_val : $urandom;
    endtask

    task automatic quiet(input int n);
        if_req = 1'b0; d_req = 1'b0; d_MemRW = MEMRW_NONE;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fetch_and_wait(input string nm, input logic [c_aw-1:0] a);
        bit got;
        got = 0;
        if_addr = a; if_req = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (if_valid) begin
                got = 1;
                chk({nm, "_err"}, err, 1'b0);
                if_req = 1'b0;
            end
        end
        chk({nm, "_done"}, got, 1'b1);
    endtask

    int  req_c, val_c, dv_c, ifr_c, nd, hi, nv;
    bit  first, done, prev, fetch_seen, got;

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        quiet(2);

        // Fetch only, ack one cycle after mem_req rises
        lat = 1; rd_fix = 1; rd_val = 32'h0000_0093;
        if_addr = 32'h0000_0100; if_req = 1'b1;
        req_c = -1; val_c = -1;
        for (int c = 0; c < 20 && val_c < 0; c++) begin
            step();
            if (mem_req && req_c < 0) begin
                req_c = c;
                chk("t1_addr", mem_addr, 32'h0000_0100);
            end
            if (if_valid) begin
                val_c = c;
                chk("t1_rdata", if_rdata, 32'h0000_0093);
                chk("t1_err", err, 1'b0);
                if_req = 1'b0;
            end else begin
                chk("t1_stall", stall, 1'b1);
            end
        end
        chk("t1_latency", val_c - req_c, 32'd2);
        rd_fix = 0;
        quiet(3);

        // Simultaneous fetch and store, zero ack latency
        lat = 0;
        if_addr = 32'h0000_0300; if_req = 1'b1;
        d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF; d_MemRW = MEMRW_STORE; d_req = 1'b1;
        first = 1; dv_c = -1; ifr_c = -1; done = 0; prev = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (mem_req && !prev) begin
                if (first) begin
                    chk("t2_first_we", mem_we, 1'b1);
                    chk("t2_first_addr", mem_addr, 32'h0000_0200);
                    chk("t2_first_wdata", mem_wdata, 32'hDEAD_BEEF);
                    first = 0;
                end else if (ifr_c < 0) begin
                    ifr_c = c;
                    chk("t2_second_addr", mem_addr, 32'h0000_0300);
                end
            end
            prev = mem_req;
            if (d_valid) begin
                dv_c = c;
                chk("t2_d_rdata", d_rdata, 32'h0);
                d_req = 1'b0; d_MemRW = MEMRW_NONE;
            end
            if (if_valid) begin if_req = 1'b0; done = 1; end
        end
        chk("t2_fetch_after_dvalid", ifr_c - dv_c, 32'd1);
        quiet(3);

        // Starvation: fetch waits through DATA_STREAK data grants
        lat = 0;
        if_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        d_MemRW = MEMRW_LOAD; d_req = 1'b1; if_req = 1'b1;
        nd = 0; fetch_seen = 0; done = 0; prev = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            step();
            if (mem_req && !prev) begin
                if (mem_addr == 32'h0000_1000) fetch_seen = 1;
                else if (!fetch_seen) nd++;
            end
            prev = mem_req;
            if (!fetch_seen) begin
                if_req = !d_valid;
            end else begin
                d_req = 1'b0; d_MemRW = MEMRW_NONE;
                if (if_valid) begin if_req = 1'b0; done = 1; end
            end
        end
        chk("t3_data_grants", nd, 32'd4);
        chk("t3_fetch_done", done, 1'b1);
        quiet(3);

        // Timeout on a load that is never acknowledged
        lat = 255;
        d_addr = 32'h0000_0400; d_MemRW = MEMRW_LOAD; d_req = 1'b1;
        hi = 0; got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            step();
            if (mem_req) hi++;
            if (d_valid) begin
                got = 1;
                chk("t4_err", err, 1'b1);
                chk("t4_d_rdata", d_rdata, 32'h0);
                d_req = 1'b0; d_MemRW = MEMRW_NONE;
            end
        end
        chk("t4_req_cycles", hi, 32'd16);
        chk("t4_valid", got, 1'b1);
        lat = 2;
        fetch_and_wait("t4_next", 32'h0000_0500);
        quiet(3);

        // Reset in the middle of a store
        lat = 255;
        d_addr = 32'h0000_0600; d_wdata = 32'h1234_5678; d_MemRW = MEMRW_STORE; d_req = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("t5_busy", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_async_drop", mem_req, 1'b0);
        d_req = 1'b0; d_MemRW = MEMRW_NONE;
        step();
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (d_valid) nv++;
        end
        chk("t5_no_dvalid", nv, 32'd0);
        lat = 1;
        fetch_and_wait("t5_fetch", 32'h0000_0700);
        quiet(3);

        // Reserved MemRW encoding is not a request
        d_req = 1'b1; d_MemRW = 2'b11; d_addr = 32'h0000_0800;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t6_no_req", mem_req, 1'b0);
            chk("t6_no_stall", stall, 1'b0);
        end
        quiet(3);

        // Randomized traffic, acks, request drops and occasional resets
        ack_rand = 1; idle_ack_en = 1;
        for (int n = 0; n < 3000; n++) begin
            step();
            ack_div = (n >= 1500 && n < 2200) ? 12 : 2;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 599) == 0) rst = 1'b1;
            if (if_req) begin
                if (if_valid) if_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_req) begin
                if (d_valid) d_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_MemRW = 2'($urandom_range(0, 3));
                d_addr = $urandom; d_wdata = $urandom;
            end
        end
        rst = 1'b0;
        ack_rand = 0; idle_ack_en = 0;
        quiet(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
